// File: rtl/mmio_timer_pkg.sv
// Shared register offsets and control-bit positions for the memory-mapped timer.
package mmio_timer_pkg;

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_PRESCALE = 3'd1;
   localparam logic [2:0] OFF_COUNT    = 3'd2;
   localparam logic [2:0] OFF_COMPARE  = 3'd3;
   localparam logic [2:0] OFF_STATUS   = 3'd4;

   localparam int unsigned CTRL_EN  = 0;
   localparam int unsigned CTRL_ARL = 1;
   localparam int unsigned CTRL_IE  = 2;

endpackage

// File: rtl/mmio_timer_tick.sv
// Prescaler: emits one tick every prescale+1 enabled cycles; a PRESCALE write restarts the period.
module tick_gen #(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  load,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pcnt_q;

   assign tick = en && (pcnt_q == prescale);

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_q <= '0;
      end else if (load) begin
         pcnt_q <= '0;
      end else if (en) begin
         pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer on the data bus: decode, register file, count/match update and read mux.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        sel,
   output logic        irq
);

   logic [2:0]            ctrl_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [31:0]           count_q;
   logic [31:0]           compare_q;
   logic                  match_q;
   logic [2:0]            off;
   logic                  wr;
   logic                  tick;
   logic                  hit;
   logic                  unused_a;

   assign unused_a = ^a[1:0];
   assign off      = a[4:2];
   assign sel      = (a[31:5] == BASE_ADDR[31:5]) && (off <= OFF_STATUS);
   assign wr       = we && sel;
   assign hit      = tick && (count_q == compare_q);
   assign irq      = match_q && ctrl_q[CTRL_IE];

   tick_gen #(
      .PRESCALE_W(PRESCALE_W)
   ) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .en      (ctrl_q[CTRL_EN]),
      .prescale(prescale_q),
      .load    (wr && (off == OFF_PRESCALE)),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         match_q    <= 1'b0;
      end else begin
         if (wr && off == OFF_CTRL)     ctrl_q     <= wd[2:0];
         if (wr && off == OFF_PRESCALE) prescale_q <= wd[PRESCALE_W-1:0];
         if (wr && off == OFF_COMPARE)  compare_q  <= wd;
         // Software write to COUNT overrides the tick increment.
         if (wr && off == OFF_COUNT) begin
            count_q <= wd;
         end else if (tick) begin
            count_q <= (hit && ctrl_q[CTRL_ARL]) ? 32'd0 : count_q + 32'd1;
         end
         // A match in the same cycle as a W1C keeps the flag set.
         if (hit) begin
            match_q <= 1'b1;
         end else if (wr && off == OFF_STATUS && wd[0]) begin
            match_q <= 1'b0;
         end
      end
   end

   always_comb begin
      rd = 32'd0;
      if (sel) begin
         case (off)
            OFF_CTRL:     rd = {29'd0, ctrl_q};
            OFF_PRESCALE: rd = {{(32-PRESCALE_W){1'b0}}, prescale_q};
            OFF_COUNT:    rd = count_q;
            OFF_COMPARE:  rd = compare_q;
            OFF_STATUS:   rd = {31'd0, match_q};
            default:      rd = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized and directed bench for mmio_timer against a cycle-level reference model.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        sel;
   logic        irq;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   logic        m_en, m_arl, m_ie;
   int unsigned m_pre;
   int unsigned m_pcnt;
   logic [31:0] m_cnt;
   logic [31:0] m_cmp;
   logic        m_match;

   logic [31:0] last_rd;
   logic        last_irq;
   logic        last_sel;

   mmio_timer #(
      .BASE_ADDR (BASE),
      .PRESCALE_W(16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .we   (we),
      .a    (a),
      .wd   (wd),
      .rd   (rd),
      .sel  (sel),
      .irq  (irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_sel(input logic [31:0] addr);
      return (addr[31:5] == BASE[31:5]) && (addr[4:0] < 5'd20);
   endfunction

   function automatic logic [31:0] m_rd(input logic [31:0] addr);
      if (!m_sel(addr)) return 32'd0;
      case (addr[4:0] / 4)
         0: return {29'd0, m_ie, m_arl, m_en};
         1: return m_pre;
         2: return m_cnt;
         3: return m_cmp;
         default: return {31'd0, m_match};
      endcase
   endfunction

   // Advance the model by one clock edge using the spec's rules.
   task automatic model_step(input logic r, input logic w, input logic [31:0] addr,
                             input logic [31:0] data);
      int    reg_idx;
      logic  wr;
      logic  tk;
      logic  mt;
      logic  [31:0] nxt_cnt;
      if (r) begin
         {m_en, m_arl, m_ie} = 3'b000;
         m_pre = 0; m_pcnt = 0; m_cnt = 0; m_cmp = 0; m_match = 1'b0;
         return;
      end
      wr      = w && m_sel(addr);
      reg_idx = addr[4:0] / 4;
      tk      = m_en && (m_pcnt == m_pre);
      mt      = tk && (m_cnt == m_cmp);
      nxt_cnt = m_cnt;
      if (tk) nxt_cnt = (mt && m_arl) ? 32'd0 : m_cnt + 1;
      if (wr && reg_idx == 2) nxt_cnt = data;
      if (wr && reg_idx == 1) m_pcnt = 0;
      else if (m_en) m_pcnt = tk ? 0 : (m_pcnt + 1) % 65536;
      if (mt) m_match = 1'b1;
      else if (wr && reg_idx == 4 && data[0]) m_match = 1'b0;
      m_cnt = nxt_cnt;
      if (wr && reg_idx == 0) {m_ie, m_arl, m_en} = data[2:0];
      if (wr && reg_idx == 1) m_pre = data[15:0];
      if (wr && reg_idx == 3) m_cmp = data;
   endtask

   // One bus cycle, entered and left at the falling edge.
   task automatic cyc(input logic r, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input bit chk = 1);
      reset = r; we = w; a = addr; wd = data;
      #1;
      last_rd = rd; last_irq = irq; last_sel = sel;
      if (chk && !r) begin
         check_eq("sel", {31'd0, sel}, {31'd0, m_sel(addr)});
         check_eq("rd", rd, m_rd(addr));
         check_eq("irq", {31'd0, irq}, {31'd0, m_match & m_ie});
      end
      @(posedge clk);
      model_step(r, w, addr, data);
      @(negedge clk);
   endtask

   task automatic wr_reg(input int idx, input logic [31:0] data);
      cyc(1'b0, 1'b1, BASE + 32'(idx * 4), data);
   endtask

   task automatic rd_reg(input int idx);
      cyc(1'b0, 1'b0, BASE + 32'(idx * 4), 32'd0);
   endtask

   initial begin
      logic [31:0] addr;
      logic [31:0] data;
      int          idx;
      reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0;
      @(negedge clk);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 0);
      cyc(1'b1, 1'b0, 32'd0, 32'd0, 0);

      // Reset state.
      for (int i = 0; i < 5; i++) begin
         rd_reg(i);
         check_eq("reset_rd", last_rd, 32'd0);
         check_eq("reset_irq", {31'd0, last_irq}, 32'd0);
      end
      cyc(1'b0, 1'b0, BASE + 32'h14, 32'd0);
      check_eq("hole_sel", {31'd0, last_sel}, 32'd0);
      check_eq("hole_rd", last_rd, 32'd0);

      // Free-running count with compare match at 5.
      wr_reg(1, 32'd0);
      wr_reg(3, 32'd5);
      wr_reg(0, 32'd5);
      for (int i = 0; i < 9; i++) begin
         rd_reg(2);
         check_eq("run_count", last_rd, 32'(i));
         check_eq("run_irq", {31'd0, last_irq}, (i >= 6) ? 32'd1 : 32'd0);
      end
      wr_reg(0, 32'd0);

      // Prescale of 3: one increment per 4 cycles, restart on PRESCALE rewrite.
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      wr_reg(1, 32'd3);
      wr_reg(0, 32'd1);
      for (int i = 0; i < 12; i++) begin
         rd_reg(2);
         check_eq("pre_count", last_rd, 32'(i / 4));
      end
      rd_reg(2);
      wr_reg(1, 32'd3);
      for (int i = 0; i < 10; i++) rd_reg(2);

      // Auto-reload at compare 2, sticky MATCH, W1C and set-wins collision.
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      wr_reg(3, 32'd2);
      wr_reg(0, 32'd3);
      for (int i = 0; i < 7; i++) begin
         rd_reg(2);
         check_eq("arl_count", last_rd, 32'(i % 3));
      end
      rd_reg(4);
      check_eq("arl_match", last_rd, 32'd1);
      wr_reg(4, 32'd1);            // count==2 here: set wins
      rd_reg(4);
      check_eq("w1c_collide", last_rd, 32'd1);
      wr_reg(4, 32'd1);            // count==1 here: clear takes effect
      rd_reg(4);
      check_eq("w1c_clear", last_rd, 32'd0);

      // Wrap-around and COUNT write during a tick.
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      wr_reg(2, 32'hFFFF_FFFE);
      wr_reg(0, 32'd1);
      rd_reg(2);
      check_eq("wrap0", last_rd, 32'hFFFF_FFFE);
      rd_reg(2);
      check_eq("wrap1", last_rd, 32'hFFFF_FFFF);
      rd_reg(2);
      check_eq("wrap2", last_rd, 32'd0);
      wr_reg(2, 32'd100);
      rd_reg(2);
      check_eq("count_wr_wins", last_rd, 32'd100);

      // Reset mid-count stops everything.
      wr_reg(0, 32'd5);
      rd_reg(2);
      cyc(1'b1, 1'b1, BASE + 32'h8, 32'd77);
      for (int i = 0; i < 5; i++) begin
         rd_reg(i);
         check_eq("midreset_rd", last_rd, 32'd0);
         check_eq("midreset_irq", {31'd0, last_irq}, 32'd0);
      end
      rd_reg(2);
      check_eq("midreset_stopped", last_rd, 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         idx  = $urandom_range(0, 7);
         addr = ($urandom_range(0, 15) == 0) ? BASE + 32'h40 + 32'(idx * 4)
                                            : BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
         case (idx)
            0:       data = $urandom_range(0, 7);
            1:       data = $urandom_range(0, 4);
            2:       data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                       : $urandom_range(0, 12);
            3:       data = $urandom_range(0, 12);
            default: data = $urandom;
         endcase
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), addr, data);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
